uart_mem_dump: RTL and testbench

- Memory read-back transmitter for the UART programming path.
- The receive side loads program/data words into memory; this block streams a memory window back out on the upg_tx line, so the host can verify what was written.
- It reads 32-bit words from the 14-bit-addressed data memory port and sends each word as 4 bytes, least-significant byte first, in 8N1 frames.
- It lives in the upg clock domain beside the UART programmer and shares the memory's upg-side read port.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_mem_dump_if.sv | 23 ++
 rtl/uart_tx_byte.sv | 113 +++++++++++
 rtl/uart_mem_dump.sv | 127 ++++++++++++
 tb/tb_uart_mem_dump.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART memory dump path: frame constants and
// the state encodings of the word sequencer and the byte serializer.
package uart_pkg;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   DATA_BITS      = 8;
    localparam int   BYTES_PER_WORD = 4;

    // The sequencer owns fetch and word bookkeeping; while a word is on the
    // wire it sits in SEND and the serializer walks START/DATA/STOP itself.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        SEND,
        FIN
    } dump_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_mem_dump_if.sv
// Word read port between the dump engine and the upg side of data memory.
// The memory answers one clock after the read strobe.
interface uart_mem_dump_if #(
    parameter int ADDR_W = 14
) ();

    logic [ADDR_W-1:0] adr;
    logic              re;
    logic [31:0]       dat;

    modport master (
        output adr,
        output re,
        input  dat
    );

    modport slave (
        input  adr,
        input  re,
        output dat
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready input. Ready is raised both when
// idle and in the final cycle of a stop bit, so a byte offered then starts
// its start bit with no idle gap between frames.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       tx_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              baudTick;
    logic              ready;

    assign baudTick   = (baud_q == BAUD_LAST);
    assign in_ready_o = ready;
    assign tx_o       = tx_q;

    // Serializer state, baud counter, bit counter and line register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= TX_IDLE;
            baud_q   <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            tx_q     <= STOP_BIT;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    // Each bit is held while the baud counter runs 0..CLKS_PER_BIT-1.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        ready    = 1'b0;

        case (state_q)
            TX_IDLE: begin
                ready = 1'b1;
                tx_d  = STOP_BIT;
            end
            TX_START: begin
                if (baudTick) begin
                    baud_d   = '0;
                    bitIdx_d = '0;
                    tx_d     = shift_q[0];
                    state_d  = TX_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (baudTick) begin
                    baud_d = '0;
                    if (bitIdx_q == BIT_LAST) begin
                        tx_d    = STOP_BIT;
                        state_d = TX_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        shift_d  = shift_q >> 1;
                        tx_d     = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (baudTick) begin
                    ready   = 1'b1;
                    baud_d  = '0;
                    tx_d    = STOP_BIT;
                    state_d = TX_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = STOP_BIT;
            end
        endcase

        if (ready && in_valid_i) begin
            state_d = TX_START;
            shift_d = in_data_i;
            baud_d  = '0;
            tx_d    = START_BIT;
        end
    end

endmodule

// File: rtl/uart_mem_dump.sv
// Streams a window of data memory out on upg_tx, one 32-bit word at a time,
// least-significant byte first, so the host can verify what was programmed.
module uart_mem_dump
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 14,
    parameter int CNT_W        = 15
) (
    input  logic              upg_clk_i,
    input  logic              upg_rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_adr_i,
    input  logic [CNT_W-1:0]  count_i,
    uart_mem_dump_if.master   mem,
    output logic              upg_tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byteIdx_q, byteIdx_d;
    logic              txValid;
    logic [7:0]        txByte;
    logic              txReady;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_i     (upg_clk_i),
        .rst_i     (upg_rst_i),
        .in_valid_i(txValid),
        .in_data_i (txByte),
        .in_ready_o(txReady),
        .tx_o      (upg_tx_o)
    );

    assign mem.adr = addr_q;
    assign mem.re  = (state_q == FETCH);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == FIN);

    // Sequencer state plus the latched window and the word being sent.
    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            word_q    <= '0;
            byteIdx_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            word_q    <= word_d;
            byteIdx_q <= byteIdx_d;
        end
    end

    // Byte 0 goes straight from the memory bus in LOAD; the rest are shifted
    // out of word_q each time the serializer can take another byte.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        word_d    = word_q;
        byteIdx_d = byteIdx_q;
        txValid   = 1'b0;
        txByte    = word_q[7:0];

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (count_i != '0) begin
                        addr_d   = base_adr_i;
                        remain_d = count_i;
                        state_d  = FETCH;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = LOAD;
            end
            LOAD: begin
                txValid = 1'b1;
                txByte  = mem.dat[7:0];
                if (txReady) begin
                    word_d    = mem.dat >> 8;
                    byteIdx_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (txReady) begin
                    if (byteIdx_q != LAST_BYTE) begin
                        txValid   = 1'b1;
                        word_d    = word_q >> 8;
                        byteIdx_d = byteIdx_q + 2'd1;
                    end else if (remain_q > CNT_W'(1)) begin
                        remain_d = remain_q - CNT_W'(1);
                        addr_d   = addr_q + ADDR_W'(1);
                        state_d  = FETCH;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump: a fast instance (4 clocks/bit) checked through a
// byte/fetch scoreboard, and a full-rate instance (87 clocks/bit) whose line
// is compared bit period by bit period.
module tb_uart_mem_dump;

    localparam int CPB_A = 4;
    localparam int CPB_B = 87;

    logic        clk;
    logic        rstA, startA, txA, busyA, doneA;
    logic [13:0] baseA;
    logic [14:0] countA;
    logic        rstB, startB, txB, busyB, doneB;
    logic [13:0] baseB;
    logic [14:0] countB;

    logic [31:0] memA [0:16383];
    logic [31:0] memB [0:16383];

    uart_mem_dump_if #(.ADDR_W(14)) memIfA ();
    uart_mem_dump_if #(.ADDR_W(14)) memIfB ();

    uart_mem_dump #(.CLKS_PER_BIT(CPB_A), .ADDR_W(14), .CNT_W(15)) dutA (
        .upg_clk_i(clk), .upg_rst_i(rstA), .start_i(startA),
        .base_adr_i(baseA), .count_i(countA), .mem(memIfA.master),
        .upg_tx_o(txA), .busy_o(busyA), .done_o(doneA)
    );

    uart_mem_dump #(.CLKS_PER_BIT(CPB_B), .ADDR_W(14), .CNT_W(15)) dutB (
        .upg_clk_i(clk), .upg_rst_i(rstB), .start_i(startB),
        .base_adr_i(baseB), .count_i(countB), .mem(memIfB.master),
        .upg_tx_o(txB), .busy_o(busyB), .done_o(doneB)
    );

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    int kCyc       = 0;
    int doneSeen   = 0;
    int doneExp    = 0;
    logic [7:0]  expByteQ[$];
    logic [13:0] expFetchQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // One-clock-latency memory models behind each read port.
    always @(posedge clk) begin
        if (memIfA.re === 1'b1) memIfA.dat <= memA[memIfA.adr];
        if (memIfB.re === 1'b1) memIfB.dat <= memB[memIfB.adr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    endtask

    // Fetch scoreboard and done pulse counter for the fast instance.
    always @(negedge clk) begin
        logic [13:0] expAdr;
        if (rstA === 1'b0 && memIfA.re === 1'b1) begin
            if (expFetchQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedFetch actual adr=%0h required no fetch", memIfA.adr);
            end else begin
                expAdr = expFetchQ.pop_front();
                checkOutput("fetchAdr", 32'(memIfA.adr), 32'(expAdr));
            end
        end
        if (rstA === 1'b0 && doneA === 1'b1) doneSeen++;
    end

    // UART receiver for the fast instance; pops the byte scoreboard.
    initial begin : byteMonitor
        logic [7:0] rx;
        logic [7:0] expB;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rstA === 1'b0 && txA === 1'b0) begin
                aborted = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB_A) begin
                        @(negedge clk);
                        if (rstA === 1'b1) aborted = 1'b1;
                    end
                    rx[b] = txA;
                end
                repeat (CPB_A) begin
                    @(negedge clk);
                    if (rstA === 1'b1) aborted = 1'b1;
                end
                if (!aborted) begin
                    checkOutput("stopBit", 32'(txA), 32'd1);
                    if (expByteQ.size() == 0) begin
                        checkCount++;
                        $display("[TB] FAIL unexpectedByte actual=%02h required none", rx);
                    end else begin
                        expB = expByteQ.pop_front();
                        checkOutput("rxByte", 32'(rx), 32'(expB));
                    end
                end
            end
        end
    end

    task automatic expectWord(input logic [13:0] adr, input logic [31:0] word);
        expFetchQ.push_back(adr);
        for (int i = 0; i < 4; i++) expByteQ.push_back(word[8*i +: 8]);
    endtask

    task automatic applyStimulus(input logic [13:0] base, input logic [14:0] count);
        @(posedge clk); #1;
        startA = 1'b1; baseA = base; countA = count;
        @(posedge clk); #1;
        startA = 1'b0; baseA = '0; countA = '0;
        kCyc = cyc;
    endtask

    task automatic advanceTo(input int off);
        while (cyc - kCyc < off) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitTxLowA(input int budget, output int off);
        off = -1;
        for (int i = 0; i < budget; i++) begin
            if (txA === 1'b0) begin off = cyc - kCyc; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic waitDoneA(input int budget, output int off);
        off = -1;
        for (int i = 0; i < budget; i++) begin
            if (doneA === 1'b1) begin off = cyc - kCyc; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic finishCheck();
        @(posedge clk); #1;
        checkOutput("donePulseWidth", 32'(doneA), 32'd0);
        checkOutput("busyAfterFin", 32'(busyA), 32'd0);
    endtask

    task automatic runSingleWord(input logic [13:0] base, input logic [31:0] word);
        int off;
        memA[base] = word;
        expectWord(base, word);
        doneExp++;
        applyStimulus(base, 15'd1);
        checkOutput("busyAfterStart", 32'(busyA), 32'd1);
        waitTxLowA(20, off);
        checkOutput("firstFallEdge", 32'(off), 32'd3);
        waitDoneA(400, off);
        checkOutput("doneEdge", 32'(off), 32'd163);
        finishCheck();
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        int off;
        int matchCnt;
        logic allHigh;
        logic [31:0] wordB;
        logic [7:0]  byteB;
        logic [39:0] bitsB;

        rstA = 1'b1; startA = 1'b0; baseA = '0; countA = '0;
        rstB = 1'b1; startB = 1'b0; baseB = '0; countB = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetTx", 32'(txA), 32'd1);
        checkOutput("resetBusy", 32'(busyA), 32'd0);
        checkOutput("resetDone", 32'(doneA), 32'd0);
        checkOutput("resetRe", 32'(memIfA.re), 32'd0);
        checkOutput("resetAdr", 32'(memIfA.adr), 32'd0);
        checkOutput("resetTxB", 32'(txB), 32'd1);
        rstA = 1'b0; rstB = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] single word");
        runSingleWord(14'h0010, 32'h12345678);

        $display("[TB] zero count");
        doneExp++;
        applyStimulus(14'h0123, 15'd0);
        checkOutput("zeroDoneNow", 32'(doneA), 32'd1);
        @(posedge clk); #1;
        checkOutput("zeroDonePulse", 32'(doneA), 32'd0);
        checkOutput("zeroBusyDrop", 32'(busyA), 32'd0);
        allHigh = 1'b1;
        repeat (20) begin
            if (txA !== 1'b1) allHigh = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("zeroTxIdle", 32'(allHigh), 32'd1);

        $display("[TB] address wrap");
        memA[14'h3FFF] = 32'hAABBCCDD;
        memA[14'h0000] = 32'h00000001;
        expectWord(14'h3FFF, 32'hAABBCCDD);
        expectWord(14'h0000, 32'h00000001);
        doneExp++;
        applyStimulus(14'h3FFF, 15'd2);
        waitTxLowA(20, off);
        checkOutput("wrapFirstFall", 32'(off), 32'd3);
        advanceTo(163);
        checkOutput("wrapGapTx", 32'(txA), 32'd1);
        checkOutput("wrapRefetchRe", 32'(memIfA.re), 32'd1);
        checkOutput("wrapRefetchAdr", 32'(memIfA.adr), 32'h0000);
        waitTxLowA(20, off);
        checkOutput("wrapSecondFall", 32'(off), 32'd166);
        waitDoneA(400, off);
        checkOutput("wrapDoneEdge", 32'(off), 32'd326);
        finishCheck();
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] start while busy");
        memA[14'h0020] = 32'hCAFEF00D;
        expectWord(14'h0020, 32'hCAFEF00D);
        doneExp++;
        applyStimulus(14'h0020, 15'd1);
        advanceTo(50);
        startA = 1'b1; baseA = 14'h0010; countA = 15'd3;
        @(posedge clk); #1;
        startA = 1'b0; baseA = '0; countA = '0;
        checkOutput("busyIgnoredStart", 32'(busyA), 32'd1);
        waitDoneA(400, off);
        checkOutput("busyDoneEdge", 32'(off), 32'd163);
        finishCheck();
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] reset mid-frame");
        expectWord(14'h0010, 32'h12345678);
        applyStimulus(14'h0010, 15'd1);
        advanceTo(16);
        rstA = 1'b1;
        @(posedge clk); #1;
        checkOutput("midResetTx", 32'(txA), 32'd1);
        checkOutput("midResetBusy", 32'(busyA), 32'd0);
        checkOutput("midResetDone", 32'(doneA), 32'd0);
        expByteQ.delete();
        rstA = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        runSingleWord(14'h0010, 32'h12345678);

        $display("[TB] bit timing at full rate");
        wordB = 32'h000000A5;
        memB[14'h0005] = wordB;
        for (int by = 0; by < 4; by++) begin
            byteB = wordB[8*by +: 8];
            bitsB[10*by] = 1'b0;
            for (int i = 0; i < 8; i++) bitsB[10*by + 1 + i] = byteB[i];
            bitsB[10*by + 9] = 1'b1;
        end
        @(posedge clk); #1;
        startB = 1'b1; baseB = 14'h0005; countB = 15'd1;
        @(posedge clk); #1;
        startB = 1'b0; baseB = '0; countB = '0;
        kCyc = cyc;
        checkOutput("bFetchRe", 32'(memIfB.re), 32'd1);
        checkOutput("bFetchAdr", 32'(memIfB.adr), 32'h0005);
        off = -1;
        for (int i = 0; i < 20; i++) begin
            if (txB === 1'b0) begin off = cyc - kCyc; break; end
            @(posedge clk); #1;
        end
        checkOutput("bFirstFall", 32'(off), 32'd3);
        for (int j = 0; j < 40; j++) begin
            matchCnt = 0;
            repeat (CPB_B) begin
                if (txB === bitsB[j]) matchCnt++;
                @(posedge clk); #1;
            end
            checkOutput($sformatf("bitPeriod%0d", j), 32'(matchCnt), 32'(CPB_B));
        end
        checkOutput("bDoneEdge", 32'(doneB), 32'd1);
        checkOutput("bIdleTx", 32'(txB), 32'd1);
        @(posedge clk); #1;
        checkOutput("bBusyDrop", 32'(busyB), 32'd0);

        repeat (10) @(posedge clk);
        #1;
        checkOutput("doneCount", 32'(doneSeen), 32'(doneExp));
        checkOutput("leftoverBytes", 32'(expByteQ.size()), 32'd0);
        checkOutput("leftoverFetches", 32'(expFetchQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
